memory_stage: RTL and testbench

//  EX/MEM pipeline register, data memory and MEM/WB pipeline register.

---
 rtl/memory_stage.sv | 178 +++++++++++++++++
 tb/tb_memory_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// ============================================================================
// memory_stage : EX/MEM register, byte-lane data memory, MEM/WB register.
// Optional debug read port enabled by defining MEM_DEBUG_PORT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module memory_stage #(
  parameter int N_BITS     = 32,
  parameter int N_BITS_REG = 6,
  parameter int ADDR_BITS  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [N_BITS-1:0]     i_aluResult,
  input  logic [N_BITS-1:0]     i_datoLeido2,
  input  logic [N_BITS_REG-1:0] i_rt_or_rd,
  input  logic                  i_ceroSignal,
  input  logic [N_BITS-1:0]     i_pcBranch,
  input  logic                  i_memToReg,
  input  logic                  i_regWrite,
  input  logic                  i_branch,
  input  logic                  i_memWrite,
  input  logic                  i_memRead,
  input  logic [1:0]            i_memSize,
  input  logic                  i_memUnsigned,
  output logic [N_BITS-1:0]     o_aluResult_EX_MEM,
  output logic [N_BITS_REG-1:0] o_rd_EX_MEM,
  output logic                  o_regWrite_EX_MEM,
  output logic                  o_pcSrc,
  output logic [N_BITS-1:0]     o_pcBranch,
  output logic [N_BITS-1:0]     o_readData,
  output logic [N_BITS-1:0]     o_aluResult,
  output logic [N_BITS_REG-1:0] o_rd,
  output logic                  o_memToReg,
  output logic                  o_regWrite,
  output logic                  o_misaligned
`ifdef MEM_DEBUG_PORT_EN
  ,
  input  logic [ADDR_BITS-1:0]  i_dbgAddr,
  output logic [N_BITS-1:0]     o_dbgData
`endif
);

  localparam int         LANES     = 4;
  localparam int         DEPTH     = 1 << ADDR_BITS;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  // EX/MEM register
  logic [N_BITS-1:0]     exm_alu, exm_store, exm_pc_branch;
  logic [N_BITS_REG-1:0] exm_rd;
  logic                  exm_zero, exm_mem_to_reg, exm_reg_write, exm_branch;
  logic                  exm_mem_write, exm_mem_read, exm_unsigned;
  logic [1:0]            exm_size;

  // MEM/WB register
  logic [N_BITS-1:0]     wb_read_data, wb_alu;
  logic [N_BITS_REG-1:0] wb_rd;
  logic                  wb_mem_to_reg, wb_reg_write, wb_misaligned;

  logic [N_BITS-1:0]     mem [0:DEPTH-1];

  logic [ADDR_BITS-1:0]  word_addr;
  logic [1:0]            lane;
  logic [N_BITS-1:0]     mem_word, wdata, load_val, load_data;
  logic [LANES-1:0]      byte_en;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic                  misaligned, store_en;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      exm_alu        <= '0;
      exm_store      <= '0;
      exm_pc_branch  <= '0;
      exm_rd         <= '0;
      exm_zero       <= 1'b0;
      exm_mem_to_reg <= 1'b0;
      exm_reg_write  <= 1'b0;
      exm_branch     <= 1'b0;
      exm_mem_write  <= 1'b0;
      exm_mem_read   <= 1'b0;
      exm_unsigned   <= 1'b0;
      exm_size       <= 2'b00;
    end else if (i_enable) begin
      exm_alu        <= i_aluResult;
      exm_store      <= i_datoLeido2;
      exm_pc_branch  <= i_pcBranch;
      exm_rd         <= i_rt_or_rd;
      exm_zero       <= i_ceroSignal;
      exm_mem_to_reg <= i_memToReg;
      exm_reg_write  <= i_regWrite;
      exm_branch     <= i_branch;
      exm_mem_write  <= i_memWrite;
      exm_mem_read   <= i_memRead;
      exm_unsigned   <= i_memUnsigned;
      exm_size       <= i_memSize;
    end
  end

  // Upper address bits are dropped so the byte address wraps onto the array.
  assign word_addr = exm_alu[ADDR_BITS+1:2];
  assign lane      = exm_alu[1:0];
  assign mem_word  = mem[word_addr];
  assign ld_byte   = mem_word[{lane, 3'b000} +: 8];
  assign ld_half   = mem_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    misaligned = (exm_mem_read | exm_mem_write) &
                 (((exm_size == SIZE_HALF) & lane[0]) | (exm_size[1] & (lane != 2'b00)));
    byte_en  = '1;
    wdata    = exm_store;
    load_val = mem_word;
    case (exm_size)
      SIZE_BYTE: begin
        byte_en  = LANES'(1) << lane;
        wdata    = {(N_BITS/8){exm_store[7:0]}};
        load_val = {{(N_BITS-8){~exm_unsigned & ld_byte[7]}}, ld_byte};
      end
      SIZE_HALF: begin
        byte_en  = lane[1] ? 4'b1100 : 4'b0011;
        wdata    = {(N_BITS/16){exm_store[15:0]}};
        load_val = {{(N_BITS-16){~exm_unsigned & ld_half[15]}}, ld_half};
      end
      default: ;
    endcase
    // A combined read+write behaves as a store, so only pure loads return data.
    load_data = (exm_mem_read & ~exm_mem_write & ~misaligned) ? load_val : '0;
    store_en  = i_reset & i_enable & exm_mem_write & ~misaligned;
  end

  always_ff @(posedge i_clk) begin
    if (store_en) begin
      for (int b = 0; b < LANES; b++) begin
        if (byte_en[b]) mem[word_addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wb_read_data  <= '0;
      wb_alu        <= '0;
      wb_rd         <= '0;
      wb_mem_to_reg <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_misaligned <= 1'b0;
    end else if (i_enable) begin
      wb_read_data  <= load_data;
      wb_alu        <= exm_alu;
      wb_rd         <= exm_rd;
      wb_mem_to_reg <= exm_mem_to_reg;
      wb_reg_write  <= exm_reg_write;
      wb_misaligned <= misaligned;
    end
  end

  assign o_aluResult_EX_MEM = exm_alu;
  assign o_rd_EX_MEM        = exm_rd;
  assign o_regWrite_EX_MEM  = exm_reg_write;
  assign o_pcSrc            = exm_branch & exm_zero;
  assign o_pcBranch         = exm_pc_branch;
  assign o_readData         = wb_read_data;
  assign o_aluResult        = wb_alu;
  assign o_rd               = wb_rd;
  assign o_memToReg         = wb_mem_to_reg;
  assign o_regWrite         = wb_reg_write;
  assign o_misaligned       = wb_misaligned;

`ifdef MEM_DEBUG_PORT_EN
  assign o_dbgData = mem[i_dbgAddr];
`endif

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// ============================================================================
// tb_memory_stage : directed self-checking bench for memory_stage.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [31:0] alu_result, store_data, pc_branch;
  logic [5:0]  rt_or_rd;
  logic        zero, mem_to_reg, reg_write, branch, mem_write, mem_read, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] alu_exm, pc_branch_out, read_data, alu_wb;
  logic [5:0]  rd_exm, rd_wb;
  logic        reg_write_exm, pc_src, mem_to_reg_wb, reg_write_wb, misaligned;
`ifdef MEM_DEBUG_PORT_EN
  logic [7:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_enable           (enable),
    .i_aluResult        (alu_result),
    .i_datoLeido2       (store_data),
    .i_rt_or_rd         (rt_or_rd),
    .i_ceroSignal       (zero),
    .i_pcBranch         (pc_branch),
    .i_memToReg         (mem_to_reg),
    .i_regWrite         (reg_write),
    .i_branch           (branch),
    .i_memWrite         (mem_write),
    .i_memRead          (mem_read),
    .i_memSize          (mem_size),
    .i_memUnsigned      (mem_unsigned),
    .o_aluResult_EX_MEM (alu_exm),
    .o_rd_EX_MEM        (rd_exm),
    .o_regWrite_EX_MEM  (reg_write_exm),
    .o_pcSrc            (pc_src),
    .o_pcBranch         (pc_branch_out),
    .o_readData         (read_data),
    .o_aluResult        (alu_wb),
    .o_rd               (rd_wb),
    .o_memToReg         (mem_to_reg_wb),
    .o_regWrite         (reg_write_wb),
    .o_misaligned       (misaligned)
`ifdef MEM_DEBUG_PORT_EN
    ,
    .i_dbgAddr          (dbg_addr),
    .o_dbgData          (dbg_data)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    enable = 1'b1; alu_result = '0; store_data = '0; rt_or_rd = '0; zero = 1'b0;
    pc_branch = '0; mem_to_reg = 1'b0; reg_write = 1'b0; branch = 1'b0;
    mem_write = 1'b0; mem_read = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
  endtask

  task automatic op_nop();
    clear_ex();
    tick();
  endtask

  task automatic op_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    clear_ex();
    alu_result = addr; store_data = data; mem_size = size; mem_write = 1'b1;
    tick();
  endtask

  task automatic op_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         input logic [5:0] rd);
    clear_ex();
    alu_result = addr; mem_size = size; mem_unsigned = uns; mem_read = 1'b1;
    mem_to_reg = 1'b1; reg_write = 1'b1; rt_or_rd = rd;
    tick();
  endtask

  task automatic op_rw(input logic [31:0] addr, input logic [31:0] data);
    clear_ex();
    alu_result = addr; store_data = data; mem_size = 2'b10; mem_write = 1'b1; mem_read = 1'b1;
    tick();
  endtask

  task automatic op_branch(input logic z, input logic [31:0] target);
    clear_ex();
    branch = 1'b1; zero = z; pc_branch = target;
    tick();
  endtask

  function automatic logic [149:0] all_outputs();
    return {alu_exm, rd_exm, reg_write_exm, pc_src, pc_branch_out, read_data, alu_wb,
            rd_wb, mem_to_reg_wb, reg_write_wb, misaligned};
  endfunction

  task automatic test_reset();
    clear_ex();
    reset = 1'b0;
    alu_result = 32'h0000_0044; mem_read = 1'b1; reg_write = 1'b1; rt_or_rd = 6'd3;
    branch = 1'b1; zero = 1'b1; pc_branch = 32'h0000_0100;
    tick(); tick();
    checks++;
    if (all_outputs() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", all_outputs());
    end
    reset = 1'b1;
    op_store(32'h04, 32'h1234_5678, 2'b10);
    op_nop();
    reset = 1'b0;
    tick(); tick();
    checks++;
    if (all_outputs() !== '0) begin
      errors++; $display("FAIL reset_after_store: got %h expected 0", all_outputs());
    end
    reset = 1'b1;
    op_load(32'h04, 2'b10, 1'b0, 6'd1);
    op_nop();
    checks++;
    if (read_data !== 32'h1234_5678) begin
      errors++; $display("FAIL reset_mem_kept: got %h expected 12345678", read_data);
    end
  endtask

  task automatic test_word_store_load();
    op_store(32'h10, 32'hDEAD_BEEF, 2'b10);
    op_load(32'h10, 2'b10, 1'b0, 6'd5);
    checks++;
    if ({alu_exm, rd_exm, reg_write_exm} !== {32'h10, 6'd5, 1'b1}) begin
      errors++; $display("FAIL fwd_ex_mem: got %h/%0d/%b expected 10/5/1", alu_exm, rd_exm, reg_write_exm);
    end
    op_nop();
    checks++;
    if (read_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL lw_data: got %h expected deadbeef", read_data);
    end
    checks++;
    if ({alu_wb, rd_wb, mem_to_reg_wb, reg_write_wb, misaligned} !== {32'h10, 6'd5, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL lw_wb_ctrl: got %h/%0d/%b%b%b expected 10/5/110",
                         alu_wb, rd_wb, mem_to_reg_wb, reg_write_wb, misaligned);
    end
  endtask

  task automatic test_extension();
    op_store(32'h20, 32'h80FF_7F01, 2'b10);
    op_load(32'h23, 2'b00, 1'b0, 6'd10);
    op_load(32'h23, 2'b00, 1'b1, 6'd11);
    checks++;
    if (read_data !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL lb: got %h expected ffffff80", read_data);
    end
    op_load(32'h22, 2'b01, 1'b0, 6'd12);
    checks++;
    if (read_data !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu: got %h expected 00000080", read_data);
    end
    op_load(32'h20, 2'b01, 1'b1, 6'd13);
    checks++;
    if (read_data !== 32'hFFFF_80FF) begin
      errors++; $display("FAIL lh: got %h expected ffff80ff", read_data);
    end
    op_nop();
    checks++;
    if ({read_data, rd_wb} !== {32'h0000_7F01, 6'd13}) begin
      errors++; $display("FAIL lhu: got %h rd %0d expected 00007f01 rd 13", read_data, rd_wb);
    end
    op_store(32'h21, 32'h0000_00AB, 2'b00);
    op_store(32'h22, 32'h1234_CDEF, 2'b01);
    op_load(32'h20, 2'b10, 1'b0, 6'd14);
    op_nop();
    checks++;
    if (read_data !== 32'hCDEF_AB01) begin
      errors++; $display("FAIL sb_sh_lanes: got %h expected cdefab01", read_data);
    end
  endtask

  task automatic test_misaligned();
    op_store(32'h21, 32'h1111_1111, 2'b10);
    op_nop();
    checks++;
    if ({misaligned, read_data} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL sw_misaligned_flag: got %b/%h expected 1/0", misaligned, read_data);
    end
    op_load(32'h20, 2'b10, 1'b0, 6'd2);
    op_load(32'h23, 2'b01, 1'b0, 6'd3);
    checks++;
    if ({misaligned, read_data} !== {1'b0, 32'hCDEF_AB01}) begin
      errors++; $display("FAIL misaligned_no_write: got %b/%h expected 0/cdefab01", misaligned, read_data);
    end
    op_nop();
    checks++;
    if ({misaligned, read_data} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL lh_misaligned: got %b/%h expected 1/0", misaligned, read_data);
    end
    op_rw(32'h30, 32'h55AA_55AA);
    op_load(32'h30, 2'b10, 1'b0, 6'd4);
    checks++;
    if ({misaligned, read_data} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL rw_read_zero: got %b/%h expected 0/0", misaligned, read_data);
    end
    op_nop();
    checks++;
    if (read_data !== 32'h55AA_55AA) begin
      errors++; $display("FAIL rw_stored: got %h expected 55aa55aa", read_data);
    end
  endtask

  task automatic test_branch();
    op_branch(1'b1, 32'h40);
    checks++;
    if ({pc_src, pc_branch_out} !== {1'b1, 32'h40}) begin
      errors++; $display("FAIL branch_taken: got %b/%h expected 1/40", pc_src, pc_branch_out);
    end
    op_branch(1'b0, 32'h80);
    checks++;
    if ({pc_src, pc_branch_out} !== {1'b0, 32'h80}) begin
      errors++; $display("FAIL branch_not_taken: got %b/%h expected 0/80", pc_src, pc_branch_out);
    end
    op_nop();
    checks++;
    if (pc_src !== 1'b0) begin
      errors++; $display("FAIL branch_cleared: got %b expected 0", pc_src);
    end
  endtask

  task automatic test_stall();
    op_load(32'h10, 2'b10, 1'b0, 6'd7);
    op_store(32'h14, 32'hCAFE_F00D, 2'b10);
    clear_ex();
    enable = 1'b0;
    alu_result = 32'h99; reg_write = 1'b1; rt_or_rd = 6'd33;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({alu_exm, read_data, rd_wb, alu_wb} !== {32'h14, 32'hDEAD_BEEF, 6'd7, 32'h10}) begin
        errors++; $display("FAIL stall_frozen[%0d]: got %h/%h/%0d/%h expected 14/deadbeef/7/10",
                           i, alu_exm, read_data, rd_wb, alu_wb);
      end
    end
    op_load(32'h14, 2'b10, 1'b0, 6'd9);
    checks++;
    if ({alu_wb, read_data, reg_write_wb} !== {32'h14, 32'h0, 1'b0}) begin
      errors++; $display("FAIL stall_release_wb: got %h/%h/%b expected 14/0/0", alu_wb, read_data, reg_write_wb);
    end
    op_nop();
    checks++;
    if (read_data !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL stall_commit: got %h expected cafef00d", read_data);
    end
    // A stalled store that is then flushed by reset must never reach memory.
    op_store(32'h18, 32'h0BAD_C0DE, 2'b10);
    op_nop();
    op_store(32'h18, 32'hFFFF_FFFF, 2'b10);
    enable = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    op_load(32'h18, 2'b10, 1'b0, 6'd8);
    op_nop();
    checks++;
    if (read_data !== 32'h0BAD_C0DE) begin
      errors++; $display("FAIL stall_no_write: got %h expected 0badc0de", read_data);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_word_store_load();
    test_extension();
    test_misaligned();
    test_branch();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
